// File: rtl/seg_scan.sv
// seg_scan: time-multiplexed seven-segment scan driver.
// A shadow register holds the value on display. A prescaler divides the clock
// into digit slots, and a registered output stage presents one nibble per slot
// with its active-low digit enable. Leading-zero blanking is optional.
module seg_scan #(
    parameter int DIGITS = 8,
    parameter int DIV    = 50000,
    localparam int IW    = (DIGITS > 1) ? $clog2(DIGITS) : 1,
    localparam int CW    = (DIV > 1) ? $clog2(DIV) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  blank_lz,
    output logic [3:0]            hex,
    output logic [DIGITS-1:0]     an,
    output logic [IW-1:0]         idx
);

    logic [4*DIGITS-1:0] r_shadow;
    logic [CW-1:0]       r_cnt;
    logic [IW-1:0]       r_sel;
    logic [3:0]          r_hex;
    logic [DIGITS-1:0]   r_an;
    logic [IW-1:0]       r_idx;

    logic                w_tick;
    logic                w_blank;
    logic [3:0]          w_nib [DIGITS];
    logic [DIGITS-1:0]   w_zero_from;
    logic [DIGITS-1:0]   w_an_next;

    assign w_tick = (r_cnt == CW'(DIV - 1));

    // Per-digit views of the shadow register. w_zero_from[k] is set when
    // nibbles k..DIGITS-1 are all zero, i.e. digit k is a leading zero.
    // Each bit is a direct reduction over the upper slice rather than a
    // ripple chain, so no bit of the vector depends on another.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        assign w_nib[gi]       = r_shadow[4*gi +: 4];
        assign w_zero_from[gi] = ~|r_shadow[4*DIGITS-1 : 4*gi];
    end

    // Digit 0 is never blanked so an all-zero value still shows one "0".
    assign w_blank = blank_lz && (r_sel != '0) && w_zero_from[r_sel];

    // One-cold enable for the selected digit; all ones when it is blanked.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_an
        assign w_an_next[gi] = !((r_sel == IW'(gi)) && !w_blank);
    end

    // Shadow register: captures the datapath value on load; reset wins over load.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow <= '0;
        end else if (load) begin
            r_shadow <= value;
        end
    end

    // Prescaler and digit index: the index advances once per DIV-cycle slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_sel <= '0;
        end else begin
            if (w_tick) begin
                r_cnt <= '0;
                if (r_sel == IW'(DIGITS - 1)) begin
                    r_sel <= '0;
                end else begin
                    r_sel <= r_sel + 1'b1;
                end
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Output register: hex and an switch on the same edge, so two digits
    // are never enabled together. The display is dark while in reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hex <= 4'h0;
            r_an  <= '1;
            r_idx <= '0;
        end else begin
            r_hex <= w_nib[r_sel];
            r_an  <= w_an_next;
            r_idx <= r_sel;
        end
    end

    assign hex = r_hex;
    assign an  = r_an;
    assign idx = r_idx;

endmodule

// File: tb/tb_seg_scan.sv
// tb_seg_scan: directed bench for seg_scan with DIGITS=8, DIV=4.
// Inputs change 1 time unit after each rising edge; outputs are sampled at
// the same point. 'e' counts rising edges since time 0; 'base' is the first
// edge after the most recent reset release.
module tb_seg_scan;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [31:0] value;
    logic        blank_lz;
    logic [3:0]  hex;
    logic [7:0]  an;
    logic [2:0]  idx;

    int total = 0;
    int bad   = 0;
    int e     = 0;
    int base  = 4;

    seg_scan #(.DIGITS(8), .DIV(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .value    (value),
        .blank_lz (blank_lz),
        .hex      (hex),
        .an       (an),
        .idx      (idx)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        e = e + 1;
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total = total + 1;
        assert (obs === exp_v) else begin
            bad = bad + 1;
            $error("FAIL %s at edge %0d: observed=%0h expected=%0h", tag, e, obs, exp_v);
        end
    endtask

    // Expected outputs for the current edge: the displayed digit advances
    // every 4 edges from 'base'; a digit is blanked when blanking is on, it
    // is not digit 0, and the value has no set bit at or above that digit.
    task automatic check_now(input string tag, input logic [31:0] val, input logic blz);
        int          d;
        logic [31:0] upper;
        logic        blanked;
        logic [7:0]  exp_an;
        d       = ((e - base) / 4) % 8;
        upper   = val >> (4 * d);
        blanked = blz && (d != 0) && (upper == 32'h0);
        exp_an  = blanked ? 8'hFF : ~(8'h01 << d);
        chk({tag, ".hex"}, {28'h0, hex}, {28'h0, upper[3:0]});
        chk({tag, ".an"},  {24'h0, an},  {24'h0, exp_an});
        chk({tag, ".idx"}, {29'h0, idx}, d[31:0]);
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; value = 32'h0; blank_lz = 1'b0;

        // Reset held for three edges: display dark, digit 0 selected.
        step(); step(); step();
        $display("reset: an=%h hex=%h idx=%0d", an, hex, idx);
        chk("reset.an",  {24'h0, an},  32'hFF);
        chk("reset.hex", {28'h0, hex}, 32'h0);
        chk("reset.idx", {29'h0, idx}, 32'h0);

        // Release reset and load in the same cycle; first output still
        // shows the old (zero) shadow on digit 0.
        rst = 1'b0; load = 1'b1; value = 32'h8765_4321;
        step();
        $display("release: an=%h hex=%h", an, hex);
        chk("release.an",  {24'h0, an},  32'hFE);
        chk("release.hex", {28'h0, hex}, 32'h0);
        load = 1'b0;

        // Scan order, 4-cycle slots and the wrap back to digit 0.
        $display("scan: value=87654321 blank_lz=0");
        while (e < 43) begin step(); check_now("scan", 32'h8765_4321, 1'b0); end

        // Leading-zero blanking on 0x00000A05.
        load = 1'b1; value = 32'h0000_0A05; blank_lz = 1'b1;
        step(); check_now("lzb_pre", 32'h8765_4321, 1'b1);
        load = 1'b0;
        $display("blank: value=00000A05 blank_lz=1");
        while (e < 80) begin step(); check_now("lzb", 32'h0000_0A05, 1'b1); end

        // Value zero: only digit 0 lit.
        load = 1'b1; value = 32'h0;
        step(); check_now("zero_pre", 32'h0000_0A05, 1'b1);
        load = 1'b0;
        $display("blank: value=00000000 blank_lz=1");
        while (e < 113) begin step(); check_now("zero", 32'h0, 1'b1); end

        // Interior zeros are shown when a higher digit is non-zero.
        load = 1'b1; value = 32'h1000_0000;
        step(); check_now("intz_pre", 32'h0, 1'b1);
        load = 1'b0;
        $display("interior: value=10000000 blank_lz=1");
        while (e < 145) begin step(); check_now("intz", 32'h1000_0000, 1'b1); end

        // Load mid-slot while digit 3 is driven: new nibble two cycles after
        // load is raised, slot boundary unchanged (digit 4 from edge 148).
        load = 1'b1; value = 32'hFFFF_FFFF;
        $display("midload: value=FFFFFFFF during digit 3");
        step(); check_now("mid_old", 32'h1000_0000, 1'b1);
        load = 1'b0;
        step(); check_now("mid_new", 32'hFFFF_FFFF, 1'b1);
        step(); check_now("mid_bound", 32'hFFFF_FFFF, 1'b1);
        step(); check_now("mid_hold", 32'hFFFF_FFFF, 1'b1);
        step(); check_now("mid_hold", 32'hFFFF_FFFF, 1'b1);

        // Edge 150 left cnt==3: load coincides with the tick edge, and the
        // next digit (5) shows the new nibble.
        load = 1'b1; value = 32'h2468_ACE1;
        $display("tickload: value=2468ACE1 in cnt==3 cycle");
        step(); check_now("tick_old", 32'hFFFF_FFFF, 1'b1);
        load = 1'b0;
        step(); check_now("tick_new", 32'h2468_ACE1, 1'b1);
        step(); check_now("tick_new", 32'h2468_ACE1, 1'b1);

        // Reset during digit 5 with load in the same cycle: load is ignored.
        rst = 1'b1; load = 1'b1; value = 32'h7777_7777;
        step();
        $display("midreset: an=%h hex=%h idx=%0d", an, hex, idx);
        chk("mrst.an",  {24'h0, an},  32'hFF);
        chk("mrst.hex", {28'h0, hex}, 32'h0);
        chk("mrst.idx", {29'h0, idx}, 32'h0);
        rst = 1'b0; load = 1'b0;
        base = e + 1;
        while (e < 171) begin step(); check_now("post_rst", 32'h0, 1'b1); end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
